// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared types and constants for the data-memory responder
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Bit positions within the error-cause vector.
  localparam int MISALIGN = 0;
  localparam int RANGE    = 1;
  localparam int BOTH_OPS = 2;
  localparam int N_ERR    = 3;

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// dmem_ram : single-port synchronous RAM, registered read, write-first
// Revision : 1.0
// ============================================================================
module dmem_ram
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 4096,
  localparam int ADDR_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;

  // Contents are deliberately not reset; only the enable path gates updates.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : MEM-stage load/store responder with wait states and checks
// Revision : 1.0
// ============================================================================
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          ADDR_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;

  logic              accept;
  logic              enter_resp;
  logic              src_re, src_we;
  logic [31:0]       src_addr;
  logic [WORD_W-1:0] src_wdata;
  logic [31:0]       offset;
  logic [N_ERR-1:0]  err_cause;
  logic              any_err;
  logic              ram_en, ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign req_ready = (state_q != WAIT);
  assign accept    = req_ready & (req_re | req_we);

  // With zero wait states the RAM is hit on the accept edge itself, so the
  // live request feeds the checks; otherwise the captured copy does.
  if (WAIT_CYCLES == 0) begin : g_src_live
    assign src_re    = req_re;
    assign src_we    = req_we;
    assign src_addr  = req_addr;
    assign src_wdata = req_wdata;
  end else begin : g_src_captured
    logic              op_re_q, op_we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        op_re_q <= 1'b0;
        op_we_q <= 1'b0;
        addr_q  <= '0;
        wdata_q <= '0;
      end else if (accept) begin
        op_re_q <= req_re;
        op_we_q <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end

    assign src_re    = op_re_q;
    assign src_we    = op_we_q;
    assign src_addr  = addr_q;
    assign src_wdata = wdata_q;
  end

  // Below-base addresses wrap to a huge offset and fail the range test.
  assign offset              = src_addr - ADDR_BASE;
  assign err_cause[MISALIGN] = |src_addr[1:0];
  assign err_cause[RANGE]    = (offset >> 2) >= 32'(DEPTH_WORDS);
  assign err_cause[BOTH_OPS] = src_re & src_we;
  assign any_err             = |err_cause;

  assign enter_resp = (WAIT_CYCLES == 0) ? accept
                                         : ((state_q == WAIT) && (cnt_q == 4'd0));
  assign ram_en     = enter_resp & ~any_err & (src_re | src_we);
  assign ram_we     = ram_en & src_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d = any_err;
      rd_d  = src_re & ~any_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (offset[ADDR_W+1:2]),
    .wdata_i (src_wdata),
    .rdata_o (ram_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & rd_q) ? ram_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// tb_dmem_responder : directed bench over four parameterisations of the DUT
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

  // Instance 0: W=1, 1: W=0, 2: W=3, 3: W=1 with base 0x1000.
  localparam int N_DUT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re    [N_DUT];
  logic        we    [N_DUT];
  logic [31:0] addr  [N_DUT];
  logic [31:0] wdata [N_DUT];
  logic        ready [N_DUT];
  logic        valid [N_DUT];
  logic [31:0] rdata [N_DUT];
  logic        err   [N_DUT];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    dmem_responder #(
      .ADDR_BASE   ((g == 3) ? 32'h0000_1000 : 32'h0000_0000),
      .DEPTH_WORDS (4096),
      .WAIT_CYCLES ((g == 1) ? 0 : (g == 2) ? 3 : 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_re    (re[g]),
      .req_we    (we[g]),
      .req_addr  (addr[g]),
      .req_wdata (wdata[g]),
      .req_ready (ready[g]),
      .rsp_valid (valid[g]),
      .rsp_rdata (rdata[g]),
      .rsp_err   (err[g])
    );
  end

  function automatic int wc(input int k);
    return (k == 1) ? 0 : (k == 2) ? 3 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where the response is visible.
  task automatic do_txn(input int k, input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd);
    int lat;
    lat = wc(k);
    chk($sformatf("%s.ready", tag), 32'(ready[k]), 32'd1);
    re[k] = r; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      if (i == 1) begin
        re[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'hFFFF_FFFF; wdata[k] = 32'h5A5A_5A5A;
      end
      if (i <= lat) chk($sformatf("%s.early%0d", tag, i), 32'(valid[k]), 32'd0);
    end
    chk($sformatf("%s.valid", tag), 32'(valid[k]), 32'd1);
    chk($sformatf("%s.err", tag), 32'(err[k]), 32'(exp_err));
    chk($sformatf("%s.rdata", tag), rdata[k], exp_rd);
  endtask

  initial begin
    for (int k = 0; k < N_DUT; k++) begin
      re[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    #1 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N_DUT; k++) begin
      chk($sformatf("rst%0d.valid", k), 32'(valid[k]), 32'd0);
      chk($sformatf("rst%0d.err", k),   32'(err[k]),   32'd0);
      chk($sformatf("rst%0d.rdata", k), rdata[k],      32'd0);
      chk($sformatf("rst%0d.ready", k), 32'(ready[k]), 32'd1);
    end
    rst = 1'b0;
    @(negedge clk);

    // W=1: store/load and error handling
    do_txn(0, "wr10",   1'b0, 1'b1, 32'h10,   32'hDEAD_BEEF, 1'b0, 32'h0);
    do_txn(0, "rd10",   1'b1, 1'b0, 32'h10,   32'h0,         1'b0, 32'hDEAD_BEEF);
    do_txn(0, "wr0",    1'b0, 1'b1, 32'h0,    32'hA5A5_0000, 1'b0, 32'h0);
    do_txn(0, "rd22",   1'b1, 1'b0, 32'h22,   32'h0,         1'b1, 32'h0);
    do_txn(0, "wr4000", 1'b0, 1'b1, 32'h4000, 32'h1234_5678, 1'b1, 32'h0);
    do_txn(0, "rd0",    1'b1, 1'b0, 32'h0,    32'h0,         1'b0, 32'hA5A5_0000);
    do_txn(0, "wr30",   1'b0, 1'b1, 32'h30,   32'h1111_2222, 1'b0, 32'h0);
    do_txn(0, "both30", 1'b1, 1'b1, 32'h30,   32'hFF,        1'b1, 32'h0);
    do_txn(0, "rd30",   1'b1, 1'b0, 32'h30,   32'h0,         1'b0, 32'h1111_2222);
    do_txn(0, "wr3ffc", 1'b0, 1'b1, 32'h3FFC, 32'h7777_8888, 1'b0, 32'h0);
    do_txn(0, "rd3ffc", 1'b1, 1'b0, 32'h3FFC, 32'h0,         1'b0, 32'h7777_8888);

    // W=0: back-to-back write then read of the same word
    do_txn(1, "b2b.wr", 1'b0, 1'b1, 32'h20, 32'h0000_1234, 1'b0, 32'h0);
    do_txn(1, "b2b.rd", 1'b1, 1'b0, 32'h20, 32'h0,         1'b0, 32'h0000_1234);
    @(negedge clk);
    chk("b2b.idle.valid", 32'(valid[1]), 32'd0);
    chk("b2b.idle.ready", 32'(ready[1]), 32'd1);

    // W=3: a request presented during WAIT is ignored
    we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'h0BAD_F00D;
    @(negedge clk);
    we[2] = 1'b0;
    chk("w3.n1.ready", 32'(ready[2]), 32'd0);
    chk("w3.n1.valid", 32'(valid[2]), 32'd0);
    re[2] = 1'b1; addr[2] = 32'h44;
    @(negedge clk);
    chk("w3.n2.ready", 32'(ready[2]), 32'd0);
    chk("w3.n2.valid", 32'(valid[2]), 32'd0);
    re[2] = 1'b0;
    @(negedge clk);
    chk("w3.n3.valid", 32'(valid[2]), 32'd0);
    @(negedge clk);
    chk("w3.n4.valid", 32'(valid[2]), 32'd1);
    chk("w3.n4.err",   32'(err[2]),   32'd0);
    @(negedge clk);
    chk("w3.n5.valid", 32'(valid[2]), 32'd0);

    // W=3: reset during WAIT of a write drops it
    we[2] = 1'b1; addr[2] = 32'h40; wdata[2] = 32'hCAFE_F00D;
    @(negedge clk);
    we[2] = 1'b0;
    chk("rstw.ready.wait", 32'(ready[2]), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstw.valid", 32'(valid[2]), 32'd0);
    chk("rstw.err",   32'(err[2]),   32'd0);
    chk("rstw.rdata", rdata[2],      32'd0);
    chk("rstw.ready", 32'(ready[2]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(2, "rstw.rd40", 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0BAD_F00D);

    // ADDR_BASE=0x1000: below-base wraps to an error
    do_txn(3, "base.wr",   1'b0, 1'b1, 32'h1000, 32'h600D_CAFE, 1'b0, 32'h0);
    do_txn(3, "base.rdlo", 1'b1, 1'b0, 32'h0FFC, 32'h0,         1'b1, 32'h0);
    do_txn(3, "base.rd",   1'b1, 1'b0, 32'h1000, 32'h0,         1'b0, 32'h600D_CAFE);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
